// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Width of the oversample tick counter.
  function automatic int unsigned cnt_width(input int unsigned oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Receiver bus: baud/line/config inputs and the captured frame fields for ErrorCheck.
interface uart_rx_sipo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx_in;
  logic [1:0]           parity_type;
  logic [DATA_BITS-1:0] raw_data;
  logic                 start_bit;
  logic                 parity_bit;
  logic                 stop_bit;
  logic                 recieved_flag;
  logic                 busy;

  modport master (
    input  baud_tick, rx_in, parity_type,
    output raw_data, start_bit, parity_bit, stop_bit, recieved_flag, busy
  );

  modport slave (
    output baud_tick, rx_in, parity_type,
    input  raw_data, start_bit, parity_bit, stop_bit, recieved_flag, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// RX line synchroniser; with RX_MAJORITY_EN defined, bit_c is a 2-of-3 vote
// over the current and two previous baud-tick samples, otherwise it is rx_s.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
`ifdef RX_MAJORITY_EN
  input  logic baud_tick,
`endif
  input  logic rx_in,
  output logic rx_s,
  output logic bit_c
);

  logic meta;

  // Two-flop synchroniser, idle-high after reset.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx_in;
      rx_s <= meta;
    end
  end

`ifdef RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      hist <= 2'b11;
    end else if (baud_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_c = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign bit_c = rx_s;
`endif

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive front end: start detection, mid-bit sampling and deserialisation.
// Define RX_MAJORITY_EN for 3-sample majority voting of each bit.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic            clk,
  input logic            reset_n,
  uart_rx_sipo_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           ptype_q, ptype_d;
  logic [DATA_BITS-1:0] raw_q, raw_d;
  logic                 start_q, start_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 flag_q, flag_d;
  logic                 busy_q, busy_d;
  logic                 rx_s, bit_c;
  logic                 mid_c, slot_c;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef RX_MAJORITY_EN
    .baud_tick (bus.baud_tick),
`endif
    .rx_in     (bus.rx_in),
    .rx_s      (rx_s),
    .bit_c     (bit_c)
  );

  assign mid_c  = (state_q == START) ? (cnt_q == MID_START) : (cnt_q == MID_BIT);
  assign slot_c = (PARITY_EN != 0) && ((ptype_q == PAR_ODD) || (ptype_q == PAR_EVEN));

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ptype_q <= PAR_NONE;
      raw_q   <= '0;
      start_q <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= 1'b1;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ptype_q <= ptype_d;
      raw_q   <= raw_d;
      start_q <= start_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and field capture; everything advances only on baud_tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ptype_d = ptype_q;
    raw_d   = raw_q;
    start_d = start_q;
    par_d   = par_q;
    stop_d  = stop_q;
    flag_d  = 1'b0;

    if (bus.baud_tick) begin
      if (state_q != IDLE) begin
        cnt_d = mid_c ? '0 : cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
            ptype_d = bus.parity_type;
          end
        end
        START: begin
          // A high sample here is a glitch: drop it without touching the fields.
          if (mid_c) begin
            if (bit_c) begin
              state_d = IDLE;
            end else begin
              start_d = bit_c;
              idx_d   = '0;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (mid_c) begin
            raw_d[idx_q] = bit_c;
            idx_d        = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              if (slot_c) begin
                state_d = PARITY;
              end else begin
                par_d   = 1'b0;
                state_d = STOP;
              end
            end
          end
        end
        PARITY: begin
          if (mid_c) begin
            par_d   = bit_c;
            state_d = STOP;
          end
        end
        STOP: begin
          if (mid_c) begin
            stop_d  = bit_c;
            flag_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.raw_data      = raw_q;
  assign bus.start_bit     = start_q;
  assign bus.parity_bit    = par_q;
  assign bus.stop_bit      = stop_q;
  assign bus.recieved_flag = flag_q;
  assign bus.busy          = busy_q;

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
UART receive front end: synchronises the serial RX line, detects the start bit, samples each bit at mid-bit using an oversampled baud tick, and deserialises the frame. Presents the captured frame fields to the downstream ErrorCheck stage: raw_data, start_bit, parity_bit, stop_bit and recieved_flag. Sits between the baud generator and ErrorCheck in the UART IP core.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first on the line
PARITY_EN, 1, 1 = parity bit slot supported; 0 = no parity slot ever, parity_type ignored
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=8)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-high
baud_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate
rx_in  in  1  asynchronous serial line, idle high
parity_type  in  2  01 odd, 10 even, 00/11 no parity; latched at start detection
raw_data  out  DATA_BITS  captured data word
start_bit  out  1  value sampled at mid start bit
parity_bit  out  1  value sampled in parity slot; 0 when no parity slot
stop_bit  out  1  value sampled at mid stop bit
recieved_flag  out  1  one-clk pulse: frame fields valid and updated
busy  out  1  high from start detection until the return to IDLE

Behaviour:
- rx_in passes through a 2-flop synchroniser (rx_s); rx_s resets to 1. All logic below uses rx_s.
- Reset: FSM=IDLE, tick counter=0, bit index=0, raw_data=0, start_bit=0, parity_bit=0, stop_bit=1, recieved_flag=0, busy=0. Asynchronous assertion mid-frame aborts the frame with no flag.
- FSM states: IDLE, START, DATA, PARITY, STOP. State changes occur only on clocks with baud_tick=1, except the recieved_flag deassertion.
- IDLE: on a baud_tick with rx_s=0, go to START, clear tick counter, latch parity_type, set busy.
- Mid-bit point: tick counter == OVERSAMPLE/2-1 in START; tick counter == OVERSAMPLE-1 in all later states. The counter wraps to 0 at each sample point.
- START: at mid-bit, sample start_bit. If the sample is 1 (false start or glitch), return to IDLE with busy=0 and no flag. If it is 0, go to DATA with bit index=0.
- DATA: at each mid-bit, shift the sample into raw_data[bit index], LSB first. After bit DATA_BITS-1, go to PARITY if PARITY_EN=1 and the latched type is 01 or 10; otherwise go to STOP.
- PARITY: at mid-bit, sample parity_bit, then go to STOP. The block does no parity check; checking is ErrorCheck's job.
- STOP: at mid-bit, sample stop_bit, pulse recieved_flag for exactly one clk on the next clock edge, and go to IDLE with busy=0. The FSM does not wait for the full stop period, so back-to-back frames are accepted. A stop sample of 0 is still reported with the flag.
- Output fields update only at their sample points and hold between frames. raw_data updates progressively during DATA.
- No baud_tick: FSM and counters hold.
- Latency: recieved_flag rises 1 clk after the baud_tick carrying the mid-stop sample, plus 2 clk of synchroniser delay.

Optional Feature:
RX_MAJORITY_EN: when defined, each bit value is the 2-of-3 majority of rx_s at the mid-bit tick and the two ticks before it; start validation uses the same vote. When undefined, a single sample is taken at the mid-bit tick. Sample positions and frame timing are identical in both builds.

Decomposition:
- Package uart_pkg: rx state enum, parity_type encodings (PAR_NONE, PAR_ODD, PAR_EVEN), OVERSAMPLE-derived counter width via $clog2.
- One sub-module, uart_rx_sync: 2-flop synchroniser plus, under RX_MAJORITY_EN, the 3-sample shift register and majority vote.

Test Plan:
- Even parity, frame 0x55 (line: 0,1,0,1,0,1,0,1,0, parity 0, stop 1) -> raw_data=0x55, start_bit=0, parity_bit=0, stop_bit=1, one-clk recieved_flag about 168 ticks after the falling edge.
- Odd parity, 0xA3 with parity bit 0 -> raw_data=0xA3, parity_bit=0, flag pulse (ErrorCheck reports the parity error).
- parity_type=00, 0x0F -> no parity slot, flag about 152 ticks after the falling edge, parity_bit=0.
- 4-tick low glitch on an idle line -> no flag, busy back to 0, outputs unchanged.
- Stop bit driven 0, 0x3C even parity -> stop_bit=0, flag still pulses; the next frame, started 8 ticks later, is received correctly.
- reset_n asserted during DATA bit 3 -> all outputs at reset values immediately, no flag; the next frame after release is received correctly.
